// File: rtl/mux8_rr_capture.sv
// Round-robin sequencer around an 8-way mux: arbitrates requests,
// drives sel, captures the mux word and offers it on valid/ready.
module mux8_rr_capture #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] mux_out,
  output logic [2:0]       sel,
  output logic [7:0]       grant,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD
  } state_t;

  state_t     state;
  logic [2:0] last_served;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       found;

  // Scan starts just past the last served channel so it ranks lowest.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_served + 3'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      grant       <= '0;
      out_data    <= '0;
      out_chan    <= '0;
      out_valid   <= 1'b0;
      last_served <= 3'd7;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            grant <= 8'b1 << pick;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          out_data  <= mux_out;
          out_chan  <= sel;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            grant       <= '0;
            last_served <= out_chan;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_capture.sv
// Bench for mux8_rr_capture: behavioural 8-way mux plus a round-robin
// reference model driving directed and randomized transactions.
module tb_mux8_rr_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [15:0] mux_out;
  logic [2:0]  sel;
  logic [7:0]  grant;
  logic [15:0] out_data;
  logic [2:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] ins [8];
  int passed = 0;
  int total  = 0;
  int last   = 7;

  always #5 clk = ~clk;

  assign mux_out = ins[sel];

  mux8_rr_capture #(.WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .mux_out(mux_out),
    .sel(sel),
    .grant(grant),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int next_ch(input logic [7:0] r, input int ls);
    for (int i = 1; i <= 8; i++) begin
      int c;
      c = (ls + i) % 8;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic load_default();
    ins[0] = 16'hAAAA; ins[1] = 16'hBBBB;
    ins[2] = 16'hCCCC; ins[3] = 16'hDDDD;
    ins[4] = 16'h0001; ins[5] = 16'h0010;
    ins[6] = 16'h0100; ins[7] = 16'h1000;
  endtask

  // One full transaction from IDLE; hold = cycles of backpressure.
  task automatic word(input int hold, input bit scramble);
    int          ch;
    logic [15:0] d;
    ch = next_ch(req, last);
    tick();
    check("grant", grant, 32'(8'b1 << ch));
    check("sel", sel, 32'(ch));
    check("valid_lo", out_valid, 0);
    if (scramble) req = 8'($urandom);
    d = ins[ch];
    tick();
    check("valid_hi", out_valid, 1);
    check("data", out_data, 32'(d));
    check("chan", out_chan, 32'(ch));
    for (int k = 0; k < hold; k++) begin
      if (scramble) begin
        req = 8'($urandom);
        ins[ch] = 16'($urandom);
      end
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 32'(d));
      check("hold_chan", out_chan, 32'(ch));
      check("hold_grant", grant, 32'(8'b1 << ch));
      check("hold_sel", sel, 32'(ch));
    end
    out_ready = 1'b1;
    tick();
    check("hs_valid", out_valid, 0);
    check("hs_grant", grant, 0);
    out_ready = 1'b0;
    last = ch;
  endtask

  initial begin
    load_default();
    reset = 1'b1;
    req = 8'hFF;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_sel", sel, 0);
    check("rst_grant", grant, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_chan", out_chan, 0);
    reset = 1'b0;
    last = 7;

    // All requesters: strict 0..7 rotation, then wrap to 0.
    for (int w = 0; w < 9; w++) begin
      check("rr_order", 32'(next_ch(req, last)), 32'(w % 8));
      word(0, 1'b0);
    end

    req = 8'b0000_1000;
    check("single_ch", 32'(next_ch(req, last)), 3);
    word(0, 1'b0);
    word(0, 1'b0);

    // Backpressure on channel 1 with req and mux input disturbed.
    req = 8'b0000_0010;
    word(5, 1'b1);
    load_default();

    req = 8'b0100_0000;
    word(0, 1'b0);
    req = 8'b0100_0001;
    check("wrap_first", 32'(next_ch(req, last)), 0);
    word(0, 1'b0);
    check("wrap_second", 32'(next_ch(req, last)), 6);
    word(0, 1'b0);

    req = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_grant", grant, 0);
      check("idle_valid", out_valid, 0);
      check("idle_sel", sel, 6);
    end

    for (int w = 0; w < 40; w++) begin
      for (int c = 0; c < 8; c++) ins[c] = 16'($urandom);
      req = 8'($urandom_range(1, 255));
      word(int'($urandom_range(0, 3)), w[0]);
    end
    load_default();

    // Reset in HOLD drops the pending word.
    req = 8'h20;
    tick();
    tick();
    tick();
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    req = 8'hFF;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_sel", sel, 0);
    reset = 1'b0;
    last = 7;
    check("post_rst_ch", 32'(next_ch(req, last)), 0);
    word(0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
